slave_to_master_mux: RTL and testbench
======================================

SLAVE_TO_MASTER_MUX -- requirements
Module: slave_to_master_mux

Interface
REQ-001 SHALL take parameters from parameters.svh: `NUM_MASTERS (default 4) master ports; `NUM_SLAVES (default 4) slave ports; `DATA_WIDTH (default 32) read-data width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- Hclk  in  1  bus clock; the single clock.
- Hreset  in  1  synchronous, active-high reset.
- Hmaster  in  $clog2(`NUM_MASTERS)  address-phase owner, from the arbiter.
- Hsel  in  `NUM_SLAVES  address-phase slave select, from the decoder.
- Htrans  in  2  muxed address-phase transfer type.
- Hrdata_S  in  `DATA_WIDTH x `NUM_SLAVES  slave read data.
- Hreadyout_S  in  1 x `NUM_SLAVES  slave ready.
- Hresp_S  in  1 x `NUM_SLAVES  slave response (0 OKAY, 1 ERROR).
- Hrdata_M  out  `DATA_WIDTH x `NUM_MASTERS  per-master read data.
- Hready_M  out  1 x `NUM_MASTERS  per-master ready.
- Hresp_M  out  1 x `NUM_MASTERS  per-master response.
- Hready  out  1  global bus ready, fed back to slaves, arbiter and decoder.

Function
REQ-003 SHALL register the data-phase context on each Hclk edge where Hready=1:
- dp_slave: index of the lowest set Hsel bit; "none" when Hsel=0.
- dp_master: Hmaster.
- dp_active: Htrans is NONSEQ or SEQ.
REQ-004 SHALL hold the data-phase context unchanged while Hready=0.
REQ-005 Hready SHALL depend on the data phase as follows:
- dp_active=0: Hready=1.
- dp_slave selects a slave: Hready = Hreadyout_S[dp_slave].
- dp_slave=none: Hready is driven by the default-slave logic (REQ-009).
REQ-006 SHALL drive Hready_M[i]=Hready for every master i.
REQ-007 Hrdata_M[dp_master] SHALL equal Hrdata_S[dp_slave]; all other masters SHALL see 0.
REQ-008 Hresp_M[dp_master] SHALL equal the selected response; all other masters SHALL see 0 (OKAY).
REQ-009 The default-slave FSM SHALL have states DS_IDLE, DS_ERR1 and DS_ERR2:
- DS_IDLE -> DS_ERR1 when a data phase starts with dp_slave=none and dp_active=1.
- DS_ERR1: Hready=0, Hresp=1; next state DS_ERR2.
- DS_ERR2: Hready=1, Hresp=1; next state DS_ERR1 if a new unmapped active transfer is accepted, otherwise DS_IDLE.
REQ-010 An unmapped data phase with dp_active=0 (IDLE/BUSY) SHALL complete as OKAY with zero wait states.
REQ-011 When dp_slave=none, read data SHALL be 0.
REQ-012 Data-phase latency SHALL be exactly one accepted cycle after the address phase; the path from slave inputs to master outputs SHALL be combinational within the data phase.
REQ-013 A back-to-back transfer to a different slave or master SHALL switch the routing only on the Hready=1 edge, with no glitch cycle to the previous owner.

Reset
REQ-014 With Hreset=1 at an Hclk edge, the block SHALL set dp_active=0, dp_slave=none, dp_master=0 and FSM=DS_IDLE.
REQ-015 The following cycle SHALL show Hready=1, all Hready_M=1, all Hresp_M=0 and all Hrdata_M=0.
REQ-016 A reset asserted during slave wait states or in DS_ERR1 SHALL abandon the transfer; no ERROR SHALL be reported after reset.

Configuration
REQ-017 Macro DEFAULT_SLAVE_EN:
- Defined: the FSM of REQ-009 is built and unmapped active transfers return a two-cycle ERROR.
- Undefined: the FSM is removed; unmapped transfers complete OKAY with zero wait states and Hrdata 0.

Verification
REQ-018 Reset: hold Hreset 2 cycles, then release -> Hready=1, all Hresp_M=0, all Hrdata_M=0.
REQ-019 Single read: master 1, Hsel=4'b0100, NONSEQ; slave 2 Hrdata=32'hA5A5_0001 with 2 wait states -> Hready low 2 cycles; Hrdata_M[1]=32'hA5A5_0001 when Hready=1; Hrdata_M[0]=0.
REQ-020 Pipelined back-to-back: master 0 to slave 0, then master 3 to slave 1 -> each data phase is routed to its own master with no cross-talk.
REQ-021 Unmapped with DEFAULT_SLAVE_EN: Hsel=0, NONSEQ, master 2 -> cycle 1 Hready=0/Hresp_M[2]=1; cycle 2 Hready=1/Hresp_M[2]=1; then OKAY. Without the macro -> Hready=1, Hresp_M[2]=0.
REQ-022 Multi-hot Hsel=4'b0110 -> slave 1 is used.
REQ-023 Reset asserted in DS_ERR1 -> next cycle Hready=1 and Hresp=0.

Source files
------------

// File: rtl/slave_to_master_mux_if.sv
// Bus bundle between the address-phase control, the slaves' response path and the per-master outputs.
// Geometry comes from the NUM_MASTERS / NUM_SLAVES / DATA_WIDTH macros (defaults 4 / 4 / 32).
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
`ifndef NUM_SLAVES
`define NUM_SLAVES 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface slave_to_master_mux_if #(
  parameter int NUM_MASTERS = `NUM_MASTERS,
  parameter int NUM_SLAVES  = `NUM_SLAVES,
  parameter int DATA_WIDTH  = `DATA_WIDTH
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [MW-1:0]                          Hmaster;
  logic [NUM_SLAVES-1:0]                  Hsel;
  logic [1:0]                             Htrans;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  Hrdata_S;
  logic [NUM_SLAVES-1:0]                  Hreadyout_S;
  logic [NUM_SLAVES-1:0]                  Hresp_S;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] Hrdata_M;
  logic [NUM_MASTERS-1:0]                 Hready_M;
  logic [NUM_MASTERS-1:0]                 Hresp_M;
  logic                                   Hready;

  // The mux itself sits on the slave side of this bundle.
  modport slave (
    input  Hmaster, Hsel, Htrans, Hrdata_S, Hreadyout_S, Hresp_S,
    output Hrdata_M, Hready_M, Hresp_M, Hready
  );

  modport master (
    output Hmaster, Hsel, Htrans, Hrdata_S, Hreadyout_S, Hresp_S,
    input  Hrdata_M, Hready_M, Hresp_M, Hready
  );
endinterface

// File: rtl/slave_to_master_mux.sv
// Data-phase response mux: routes the addressed slave's rdata/ready/resp back to the owning master.
// Define DEFAULT_SLAVE_EN to build the default slave (two-cycle ERROR for unmapped active transfers).
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
`ifndef NUM_SLAVES
`define NUM_SLAVES 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module slave_to_master_mux_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  own,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] rdata_sel,
  input  logic                  resp_sel,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  resp
);
  assign rdata = own ? rdata_sel : '0;
  assign resp  = own & resp_sel;
  assign ready = hready;
endmodule

module slave_to_master_mux #(
  parameter int NUM_MASTERS = `NUM_MASTERS,
  parameter int NUM_SLAVES  = `NUM_SLAVES,
  parameter int DATA_WIDTH  = `DATA_WIDTH
) (
  input logic                  Hclk,
  input logic                  Hreset,
  slave_to_master_mux_if.slave bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES  > 1) ? $clog2(NUM_SLAVES)  : 1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  logic [SW-1:0] a_slave;
  logic          a_none;
  logic          a_active;
  logic          a_unmapped_act;

  logic [SW-1:0] dp_slave_q,  dp_slave_d;
  logic          dp_none_q,   dp_none_d;
  logic [MW-1:0] dp_master_q, dp_master_d;
  logic          dp_active_q, dp_active_d;

  logic                  hready;
  logic                  resp_sel;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  ds_ready;
  logic                  ds_resp;

  // Lowest set select bit wins when the decoder presents a multi-hot Hsel.
  always_comb begin
    a_slave = '0;
    a_none  = 1'b1;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (bus.Hsel[s]) begin
        a_slave = SW'(s);
        a_none  = 1'b0;
      end
    end
  end

  assign a_active       = (bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ);
  assign a_unmapped_act = a_none & a_active;

  always_comb begin
    dp_slave_d  = dp_slave_q;
    dp_none_d   = dp_none_q;
    dp_master_d = dp_master_q;
    dp_active_d = dp_active_q;
    if (hready) begin
      dp_slave_d  = a_slave;
      dp_none_d   = a_none;
      dp_master_d = bus.Hmaster;
      dp_active_d = a_active;
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      dp_slave_q  <= '0;
      dp_none_q   <= 1'b1;
      dp_master_q <= '0;
      dp_active_q <= 1'b0;
    end else begin
      dp_slave_q  <= dp_slave_d;
      dp_none_q   <= dp_none_d;
      dp_master_q <= dp_master_d;
      dp_active_q <= dp_active_d;
    end
  end

`ifdef DEFAULT_SLAVE_EN
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;
  ds_state_e ds_state_q, ds_state_d;

  // ds_ready/ds_resp depend only on the state register, so hready feeding the
  // next-state logic does not close a combinational loop.
  always_comb begin
    ds_state_d = ds_state_q;
    ds_ready   = 1'b1;
    ds_resp    = 1'b0;
    unique case (ds_state_q)
      DS_IDLE: begin
        if (hready && a_unmapped_act) ds_state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready   = 1'b0;
        ds_resp    = 1'b1;
        ds_state_d = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp    = 1'b1;
        ds_state_d = a_unmapped_act ? DS_ERR1 : DS_IDLE;
      end
      default: ds_state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) ds_state_q <= DS_IDLE;
    else        ds_state_q <= ds_state_d;
  end
`else
  assign ds_ready = 1'b1;
  assign ds_resp  = 1'b0;
`endif

  always_comb begin
    hready    = 1'b1;
    resp_sel  = 1'b0;
    rdata_sel = '0;
    if (dp_none_q) begin
      resp_sel = ds_resp;
      if (dp_active_q) hready = ds_ready;
    end else begin
      resp_sel  = bus.Hresp_S[dp_slave_q];
      rdata_sel = bus.Hrdata_S[dp_slave_q];
      if (dp_active_q) hready = bus.Hreadyout_S[dp_slave_q];
    end
  end

  assign bus.Hready = hready;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_lane
    slave_to_master_mux_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .own       (dp_master_q == MW'(m)),
      .hready    (hready),
      .rdata_sel (rdata_sel),
      .resp_sel  (resp_sel),
      .rdata     (bus.Hrdata_M[m]),
      .ready     (bus.Hready_M[m]),
      .resp      (bus.Hresp_M[m])
    );
  end
endmodule

// File: tb/tb_slave_to_master_mux.sv
// Cycle-driven bench: each stimulus cycle pushes its expected outputs, a negedge monitor pops and compares.
module tb_slave_to_master_mux;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;
  localparam logic [3:0] ALL  = 4'hF;
  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'hA5A5_0001;
  localparam logic [31:0] D3 = 32'h4444_0003;

  typedef struct {
    string        tag;
    logic         rdy;
    logic [3:0]   resp;
    logic [127:0] rdata;
  } exp_t;

  logic Hclk;
  logic Hreset;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  slave_to_master_mux_if #(.NUM_MASTERS(4), .NUM_SLAVES(4), .DATA_WIDTH(32)) bus ();

  slave_to_master_mux #(.NUM_MASTERS(4), .NUM_SLAVES(4), .DATA_WIDTH(32)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rd(input int m, input logic [31:0] v);
    logic [3:0][31:0] r;
    r    = '0;
    r[m] = v;
    return r;
  endfunction

  always @(negedge Hclk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".hready"},   128'(bus.Hready),   128'(e.rdy));
      chk({e.tag, ".hready_m"}, 128'(bus.Hready_M), 128'({4{e.rdy}}));
      chk({e.tag, ".hresp_m"},  128'(bus.Hresp_M),  128'(e.resp));
      chk({e.tag, ".hrdata_m"}, 128'(bus.Hrdata_M), e.rdata);
    end
  end

  // One bus cycle: drive address phase + slave response, record what the data phase must show.
  task automatic cyc(input logic rst, input int m, input logic [3:0] sel, input logic [1:0] tr,
                     input logic [3:0] rdy_s, input logic [3:0] resp_s, input string tag,
                     input logic er, input logic [3:0] eresp, input logic [127:0] erd);
    exp_t e;
    #1;
    Hreset          = rst;
    bus.Hmaster     = m[1:0];
    bus.Hsel        = sel;
    bus.Htrans      = tr;
    bus.Hreadyout_S = rdy_s;
    bus.Hresp_S     = resp_s;
    e.tag   = tag;
    e.rdy   = er;
    e.resp  = eresp;
    e.rdata = erd;
    sb.push_back(e);
    @(posedge Hclk);
  endtask

  initial begin
    Hreset          = 1'b1;
    bus.Hmaster     = '0;
    bus.Hsel        = '0;
    bus.Htrans      = IDLE;
    bus.Hreadyout_S = ALL;
    bus.Hresp_S     = '0;
    bus.Hrdata_S[0] = D0;
    bus.Hrdata_S[1] = D1;
    bus.Hrdata_S[2] = D2;
    bus.Hrdata_S[3] = D3;
    repeat (2) @(posedge Hclk);

    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "reset", 1, 4'b0000, '0);

    // Read with two wait states; the next (held) request must not be captured until ready.
    cyc(0, 1, 4'b0100, NSEQ, ALL,     4'b0000, "rd_addr",  1, 4'b0000, '0);
    cyc(0, 3, 4'b0001, NSEQ, 4'b1011, 4'b0000, "rd_wait1", 0, 4'b0000, rd(1, D2));
    cyc(0, 3, 4'b0001, NSEQ, 4'b1011, 4'b0000, "rd_wait2", 0, 4'b0000, rd(1, D2));
    cyc(0, 3, 4'b0001, NSEQ, ALL,     4'b0000, "rd_done",  1, 4'b0000, rd(1, D2));
    cyc(0, 0, 4'b0000, IDLE, ALL,     4'b0000, "rd2_data", 1, 4'b0000, rd(3, D0));
    cyc(0, 0, 4'b0000, IDLE, ALL,     4'b0000, "idle0",    1, 4'b0000, '0);

    // Pipelined: master 0 -> slave 0, then master 3 -> slave 1 (slave 1 answers ERROR).
    cyc(0, 0, 4'b0001, NSEQ, ALL, 4'b0010, "pp_a0",   1, 4'b0000, '0);
    cyc(0, 3, 4'b0010, NSEQ, ALL, 4'b0010, "pp_d0",   1, 4'b0000, rd(0, D0));
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0010, "pp_d1",   1, 4'b1000, rd(3, D1));
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0010, "pp_idle", 1, 4'b0000, '0);

    // Multi-hot select resolves to slave 1.
    cyc(0, 2, 4'b0110, SEQ,  ALL, 4'b0000, "mh_a", 1, 4'b0000, '0);
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "mh_d", 1, 4'b0000, rd(2, D1));

    // Mapped IDLE transfer: slave readiness ignored, zero wait states.
    cyc(0, 1, 4'b1000, IDLE, ALL,     4'b0000, "im_a", 1, 4'b0000, '0);
    cyc(0, 0, 4'b0000, IDLE, 4'b0111, 4'b0000, "im_d", 1, 4'b0000, rd(1, D3));

    // Unmapped active transfer.
    cyc(0, 2, 4'b0000, NSEQ, ALL, 4'b0000, "um_a", 1, 4'b0000, '0);
`ifdef DEFAULT_SLAVE_EN
    cyc(0, 2, 4'b0000, NSEQ, ALL, 4'b0000, "um_err1", 0, 4'b0100, '0);
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "um_err2", 1, 4'b0100, '0);
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "um_ok",   1, 4'b0000, '0);
`else
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "um_d",  1, 4'b0000, '0);
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "um_ok", 1, 4'b0000, '0);
`endif

    // Unmapped IDLE transfer completes OKAY.
    cyc(0, 2, 4'b0000, IDLE, ALL, 4'b0000, "ui_a", 1, 4'b0000, '0);
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "ui_d", 1, 4'b0000, '0);

    // Reset during the first error cycle (plain OKAY phase when no default slave).
    cyc(0, 1, 4'b0000, NSEQ, ALL, 4'b0000, "re_a", 1, 4'b0000, '0);
`ifdef DEFAULT_SLAVE_EN
    cyc(1, 0, 4'b0000, IDLE, ALL, 4'b0000, "re_err1", 0, 4'b0010, '0);
`else
    cyc(1, 0, 4'b0000, IDLE, ALL, 4'b0000, "re_d", 1, 4'b0000, '0);
`endif
    cyc(0, 0, 4'b0000, IDLE, ALL, 4'b0000, "re_after", 1, 4'b0000, '0);

    // Reset during a slave wait state abandons the transfer.
    cyc(0, 1, 4'b0100, NSEQ, ALL,     4'b0000, "rw_a",     1, 4'b0000, '0);
    cyc(1, 0, 4'b0000, IDLE, 4'b1011, 4'b0100, "rw_wait",  0, 4'b0010, rd(1, D2));
    cyc(0, 0, 4'b0000, IDLE, ALL,     4'b0100, "rw_after", 1, 4'b0000, '0);

    #1;
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
